uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
// - UART receive frame engine. Oversamples serial rx_in, validates the start bit, and shifts
//   in DATA_WIDTH data bits LSB first. It then checks the optional parity bit and the stop bit.
// - Emits the parallel word with a 1-cycle data_valid strobe.
// - Receive-side counterpart of the TX serializer/parity path; sits between the RX pin
//   synchronizer and the RX FIFO/register interface.
// PARAMETERS
// - DATA_WIDTH      8  data bits per frame
// - PRESCALE_WIDTH  6  width of prescale input (clocks per bit)
// PORTS
// - clk          in   1               system clock, rising edge
// - rst          in   1               async reset, active-high
// - rx_in        in   1               serial line, already synchronized to clk, idle high
// - prescale     in   PRESCALE_WIDTH  clocks per bit; legal: even, 8..32
// - parity_en    in   1               1: frame carries parity bit
// - parity_type  in   1               0: even, 1: odd
// - data_out     out  DATA_WIDTH      last good received word
// - data_valid   out  1               1-cycle strobe, data_out updated this cycle
// - parity_error out  1               1-cycle strobe, parity mismatch
// - stop_error   out  1               1-cycle strobe, stop bit sampled low
// BEHAVIOUR
// - Reset: state=IDLE, all counters 0, data_out=0, data_valid=0, parity_error=0, stop_error=0.
//   A reset mid-frame discards the frame; no strobes are emitted.
// - Config latch: prescale, parity_en and parity_type are captured on the IDLE->START
//   transition and held for the whole frame. Changes mid-frame take effect on the next frame.
// - Timing: edge_cnt runs 0..P-1 per bit (P = latched prescale), then wraps and advances
//   the bit. Sample point is edge_cnt==P/2. The IDLE cycle that sees rx_in==0 is start-bit
//   edge_cnt 0.
// - FSM:
//   - IDLE: rx_in==0 -> START.
//   - START: sampled 1 -> IDLE (glitch; no strobe). Sampled 0 -> DATA at bit end.
//   - DATA: shift the sampled bit into data_shift[bit_cnt], LSB first. After bit
//     DATA_WIDTH-1 ends -> PARITY if parity_en, else STOP.
//   - PARITY: par_err = sampled ^ (^data_shift) ^ parity_type. Go to STOP at bit end.
//   - STOP: act at the sample point, not at bit end; the remaining half bit is the
//     resync margin for back-to-back frames.
//     - Sampled 1 and !par_err -> data_out<=data_shift, data_valid=1, -> IDLE.
//     - Sampled 1 and par_err -> parity_error=1, data_out unchanged, -> IDLE.
//     - Sampled 0 -> stop_error=1, plus parity_error=1 if par_err; data_out unchanged;
//       -> BREAK_WAIT.
//   - BREAK_WAIT: stay while rx_in==0 (break / line held low); rx_in==1 -> IDLE.
// - Latency: strobes are registered and assert the cycle after the STOP sample clock, for
//   exactly one cycle. data_valid is never asserted together with either error strobe.
// - Frame length: 1 + DATA_WIDTH + parity_en + 1 bits. A new start edge is accepted from the
//   first IDLE cycle after the stop sample point.
// - data_out holds its value between valid frames.
// - Illegal prescale (odd, <8, >32) is unsupported; behaviour is unspecified.
// CONFIGURATION
// - RX_MAJORITY_VOTE_EN defined: each bit is sampled at edge_cnt P/2-1, P/2 and P/2+1, and the
//   value is the 2-of-3 majority. It is resolved at P/2+1; all sample-point actions above
//   (glitch reject, shifts, strobes, STOP->IDLE) move to P/2+1, adding 1 cycle of latency.
// - Undefined: single sample at P/2. A glitch covering only P/2 corrupts the bit.
// TESTING
// - P=8, parity_en=1, parity_type=0, frame 0xA5 with parity bit 0 -> data_out=0xA5,
//   data_valid pulses once, no errors.
// - Same frame with parity_type=1 -> parity_error pulses once, data_valid=0, data_out keeps
//   its previous value.
// - P=8, rx_in low for 2 clocks, then high -> return to IDLE, no strobes. A following valid
//   0x3C frame is received correctly.
// - P=16, parity_en=0, frames 0x00 then 0xFF back-to-back (no idle gap) -> two data_valid
//   strobes, data_out 0x00 then 0xFF.
// - rx_in held low 40 bit-times, then high -> exactly one stop_error, no data_valid, no new
//   frame until rx_in returns high. Next frame 0x81 is received OK.
// - rst pulsed during DATA bit 4 -> all outputs 0 next cycle, no strobes. A later 0x5A frame
//   is received OK.
// - With RX_MAJORITY_VOTE_EN, a 1-clock inverted glitch at P/2 of data bit 2 -> word is still
//   correct.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receive frame engine: start/data/parity/stop deframing with registered strobes.
// Optional build macro RX_MAJORITY_VOTE_EN enables 2-of-3 majority sampling around mid-bit.
module uart_rx_deframer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      parity_en,
    input  logic                      parity_type,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      stop_error
);

    localparam int unsigned PW        = PRESCALE_WIDTH;
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int unsigned SAMPLE_OFS = 1;
`else
    localparam int unsigned SAMPLE_OFS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  data_shift_q, data_shift_d;
    logic                   par_err_q, par_err_d;
    logic [PW-1:0]          p_q, p_d;
    logic                   pen_q, pen_d;
    logic                   ptype_q, ptype_d;
    logic [DATA_WIDTH-1:0]  data_out_d;
    logic                   data_valid_d, parity_error_d, stop_error_d;
`ifdef RX_MAJORITY_VOTE_EN
    logic                   s0_q, s0_d, s1_q, s1_d;
`endif

    logic [PW-1:0]          half;
    logic [PW-1:0]          edge_inc;
    logic                   sample_pt;
    logic                   bit_end;
    logic                   sampled;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            data_shift_q <= '0;
            par_err_q    <= 1'b0;
            p_q          <= '0;
            pen_q        <= 1'b0;
            ptype_q      <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
`ifdef RX_MAJORITY_VOTE_EN
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_shift_q <= data_shift_d;
            par_err_q    <= par_err_d;
            p_q          <= p_d;
            pen_q        <= pen_d;
            ptype_q      <= ptype_d;
            data_out     <= data_out_d;
            data_valid   <= data_valid_d;
            parity_error <= parity_error_d;
            stop_error   <= stop_error_d;
`ifdef RX_MAJORITY_VOTE_EN
            s0_q         <= s0_d;
            s1_q         <= s1_d;
`endif
        end
    end

    // Next-state, bit timing and strobe generation
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        data_shift_d   = data_shift_q;
        par_err_d      = par_err_q;
        p_d            = p_q;
        pen_d          = pen_q;
        ptype_d        = ptype_q;
        data_out_d     = data_out;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        half      = p_q >> 1;
        sample_pt = (edge_cnt_q == half + PW'(SAMPLE_OFS));
        bit_end   = (edge_cnt_q == p_q - PW'(1));
        edge_inc  = bit_end ? '0 : edge_cnt_q + PW'(1);

`ifdef RX_MAJORITY_VOTE_EN
        s0_d = s0_q;
        s1_d = s1_q;
        if (edge_cnt_q == half - PW'(1)) s0_d = rx_in;
        if (edge_cnt_q == half)          s1_d = rx_in;
        sampled = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
`else
        sampled = rx_in;
`endif

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (!rx_in) begin
                    // This cycle is edge 0 of the start bit
                    state_d    = START;
                    edge_cnt_d = PW'(1);
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    p_d        = prescale;
                    pen_d      = parity_en;
                    ptype_d    = parity_type;
                end
            end
            START: begin
                edge_cnt_d = edge_inc;
                if (sample_pt && sampled) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                edge_cnt_d = edge_inc;
                if (sample_pt) data_shift_d[bit_cnt_q] = sampled;
                if (bit_end) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                edge_cnt_d = edge_inc;
                if (sample_pt) par_err_d = sampled ^ (^data_shift_q) ^ ptype_q;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                edge_cnt_d = edge_inc;
                // Act mid-stop-bit; the rest of the bit is resync margin
                if (sample_pt) begin
                    edge_cnt_d = '0;
                    if (sampled) begin
                        state_d = IDLE;
                        if (par_err_q) begin
                            parity_error_d = 1'b1;
                        end else begin
                            data_out_d   = data_shift_q;
                            data_valid_d = 1'b1;
                        end
                    end else begin
                        state_d        = BREAK_WAIT;
                        stop_error_d   = 1'b1;
                        parity_error_d = par_err_q;
                    end
                end
            end
            BREAK_WAIT: begin
                edge_cnt_d = '0;
                if (rx_in) state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized scoreboard bench for uart_rx_deframer; expectations come from frame-level rules.
module tb_uart_rx_deframer;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int MV_LAT = 1;
`else
    localparam int MV_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    uart_rx_deframer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       perr;
        logic       serr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [7:0] exp_dout = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and tracks data_out hold
    always @(negedge clk) begin
        if (rst) begin
            chk({data_out, data_valid, parity_error, stop_error} == 11'd0, "reset_outputs",
                int'({data_out, data_valid, parity_error, stop_error}), 0);
            exp_dout = 8'h00;
        end else begin
            if (q.size() > 0 && cyc > q[0].cyc) begin
                mon_e = q.pop_front();
                chk(1'b0, "missed_strobe", 0, mon_e.cyc);
            end
            if (data_valid || parity_error || stop_error) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe", int'({data_valid, parity_error, stop_error}), 0);
                end else begin
                    mon_e = q.pop_front();
                    chk({data_valid, parity_error, stop_error} == {mon_e.valid, mon_e.perr, mon_e.serr},
                        "strobe_kind", int'({data_valid, parity_error, stop_error}),
                        int'({mon_e.valid, mon_e.perr, mon_e.serr}));
                    chk(cyc == mon_e.cyc, "strobe_cycle", cyc, mon_e.cyc);
                    if (mon_e.valid) exp_dout = mon_e.data;
                end
            end
            chk(data_out == exp_dout, "data_out", int'(data_out), int'(exp_dout));
        end
    end

    task automatic hold(input int n);
        if (n > 0) repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        prescale    = 6'(2 * $urandom_range(4, 16));
        parity_en   = 1'($urandom_range(0, 1));
        parity_type = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bit(input logic b, input int p, input bit glitch);
        rx_in = b;
        if (glitch) begin
            hold(p / 2);
            rx_in = ~b;
            hold(1);
            rx_in = b;
            hold(p - p / 2 - 1);
        end else begin
            hold(p);
        end
    endtask

    // Sends one frame; the expected outcome is decided up front from frame-level rules
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptype,
                              input bit flip_par, input bit stop_b, input int glitch_bit);
        logic [7:0] dexp;
        logic       pbit;
        bit         perr;
        int         nb;
        exp_t       e;
        pbit = (^d) ^ ptype ^ flip_par;
        dexp = d;
`ifndef RX_MAJORITY_VOTE_EN
        if (glitch_bit >= 0) dexp[glitch_bit] = ~d[glitch_bit];
`endif
        perr = pen && ((($countones(dexp) + int'(pbit)) % 2) != int'(ptype));
        nb   = 10 + int'(pen);
        prescale    = 6'(p);
        parity_en   = pen;
        parity_type = ptype;
        rx_in       = 1'b0;
        e.valid = stop_b && !perr;
        e.perr  = perr;
        e.serr  = !stop_b;
        e.data  = dexp;
        e.cyc   = cyc + 1 + (nb - 1) * p + p / 2 + MV_LAT;
        q.push_back(e);
        hold(1);
        rand_cfg();
        hold(p - 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, glitch_bit == i);
        if (pen) drive_bit(pbit, p, 1'b0);
        drive_bit(stop_b, p, 1'b0);
        if (!stop_b) begin
            rx_in = 1'b1;
            hold(p);
        end
    endtask

    task automatic send_break(input int p, input bit pen, input bit ptype, input int bits);
        exp_t e;
        prescale    = 6'(p);
        parity_en   = pen;
        parity_type = ptype;
        rx_in       = 1'b0;
        e.valid = 1'b0;
        e.perr  = pen && ptype;
        e.serr  = 1'b1;
        e.data  = 8'h00;
        e.cyc   = cyc + 1 + (9 + int'(pen)) * p + p / 2 + MV_LAT;
        q.push_back(e);
        hold(bits * p);
        rx_in = 1'b1;
        hold(p);
    endtask

    task automatic send_abort(input logic [7:0] d, input int p, input int abort_bit);
        prescale  = 6'(p);
        parity_en = 1'b0;
        rx_in     = 1'b0;
        hold(p);
        for (int i = 0; i < abort_bit; i++) drive_bit(d[i], p, 1'b0);
        rx_in = d[abort_bit];
        hold(p / 2);
        rst = 1'b1;
        hold(1);
        chk(data_out == 8'h00, "abort_data_out", int'(data_out), 0);
        chk({data_valid, parity_error, stop_error} == 3'b000, "abort_strobes",
            int'({data_valid, parity_error, stop_error}), 0);
        rst   = 1'b0;
        rx_in = 1'b1;
        hold(2 * p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        bit  pen, ptype, flip, stop_b;
        int  gb;
        rst         = 1'b1;
        rx_in       = 1'b1;
        prescale    = 6'd8;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        hold(3);
        chk({data_out, data_valid, parity_error, stop_error} == 11'd0, "reset_state",
            int'({data_out, data_valid, parity_error, stop_error}), 0);
        rst = 1'b0;
        hold(2);

        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        hold(8);
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        hold(8);

        rx_in = 1'b0;
        hold(2);
        rx_in = 1'b1;
        hold(16);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(16);

        send_break(8, 1'b0, 1'b0, 40);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(8);

        send_abort(8'hC3, 8, 4);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        hold(8);

        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        send_break(12, 1'b1, 1'b1, 20);

        for (int n = 0; n < 40; n++) begin
            p      = 2 * $urandom_range(4, 16);
            pen    = 1'($urandom_range(0, 1));
            ptype  = 1'($urandom_range(0, 1));
            flip   = ($urandom_range(0, 4) == 0);
            stop_b = ($urandom_range(0, 7) != 0);
            gb     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(8'($urandom), p, pen, ptype, flip, stop_b, gb);
            hold(int'($urandom_range(0, 1)) * p);
        end

        hold(128);
        chk(q.size() == 0, "queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
